// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// MULT/MULTU produce a full 2*WIDTH product through MUL_LATENCY register
// stages. DIV/DIVU run a restoring radix-2 divider: WIDTH iterations plus one
// sign-fixup edge. MTHI/MTLO write hi/lo in a single edge with no done pulse.
//
// Optional feature macro: MDU_EARLY_OUT_EN. When defined, a nonzero-divisor
// divide whose |dividend| < |divisor| skips the iteration phase entirely.
//
// Parameters:
//   WIDTH        operand width, >= 4 and even
//   MUL_LATENCY  edges from accept to hi/lo update for multiplies, 1..4
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_op         0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   i_op_valid   op/operands valid this cycle
//   o_op_ready   unit idle and able to accept
//   i_cancel     abort an in-flight MUL/DIV
//   i_rs, i_rt   operands
//   o_stall      hold the PC while a MUL/DIV is outstanding
//   o_done       one-cycle pulse when hi/lo hold a new MUL/DIV result
//   o_dz         sticky divide-by-zero flag
//   o_hi, o_lo   HI/LO registers
module mdu_iter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       i_op,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic             i_cancel,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {StIdle, StMul, StDivIter, StDivFix} state_e;

  state_e r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dz;
  logic [2*WIDTH-1:0] r_mul_pipe [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] r_mul_vld;
  logic [WIDTH-1:0]   r_dvs, r_quo, r_rem;
  logic [CntW-1:0]    r_cnt;
  logic               r_q_neg, r_r_neg, r_dz_pend;

  // Decode and accept
  logic w_idle, w_op_legal, w_is_mul, w_is_div, w_accept, w_acc_mul, w_acc_div, w_cancel;
  assign w_idle     = (r_state == StIdle);
  assign w_op_legal = (i_op >= OpMult) && (i_op <= OpMtlo);
  assign w_is_mul   = (i_op == OpMult) || (i_op == OpMultu);
  assign w_is_div   = (i_op == OpDiv) || (i_op == OpDivu);
  // Cancel also blocks an accept in IDLE.
  assign w_accept   = i_op_valid && w_idle && w_op_legal && !i_cancel;
  assign w_acc_mul  = w_accept && w_is_mul;
  assign w_acc_div  = w_accept && w_is_div;
  assign w_cancel   = i_cancel && !w_idle;

  // Multiplier operands, sign- or zero-extended to 2*WIDTH
  logic               w_mul_sgn;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
  assign w_mul_sgn = (i_op == OpMult);
  assign w_mul_a   = {{WIDTH{w_mul_sgn & i_rs[WIDTH-1]}}, i_rs};
  assign w_mul_b   = {{WIDTH{w_mul_sgn & i_rt[WIDTH-1]}}, i_rt};
  assign w_prod    = w_mul_a * w_mul_b;

  logic w_mul_last;
  assign w_mul_last = r_mul_vld[MUL_LATENCY-1];

  // Divider operand magnitudes
  logic             w_div_sgn, w_rs_neg, w_rt_neg, w_rt_zero, w_early, w_div_skip;
  logic [WIDTH-1:0] w_rs_abs, w_rt_abs;
  assign w_div_sgn = (i_op == OpDiv);
  assign w_rs_neg  = w_div_sgn & i_rs[WIDTH-1];
  assign w_rt_neg  = w_div_sgn & i_rt[WIDTH-1];
  assign w_rs_abs  = w_rs_neg ? -i_rs : i_rs;
  assign w_rt_abs  = w_rt_neg ? -i_rt : i_rt;
  assign w_rt_zero = (i_rt == '0);
`ifdef MDU_EARLY_OUT_EN
  assign w_early   = !w_rt_zero && (w_rs_abs < w_rt_abs);
`else
  assign w_early   = 1'b0;
`endif
  assign w_div_skip = w_rt_zero || w_early;

  // One restoring iteration. rem < divisor always holds, so the shifted
  // remainder fits in WIDTH+1 bits and the trial's top bit is the borrow.
  logic [WIDTH:0]   w_rem_sh, w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = !w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    o_op_ready  = w_idle;
    o_stall     = (i_op_valid && (w_is_mul || w_is_div) && !r_done) || !w_idle;
    unique case (r_state)
      StIdle: begin
        if (w_acc_mul)      w_state_nxt = StMul;
        else if (w_acc_div) w_state_nxt = w_div_skip ? StDivFix : StDivIter;
      end
      StMul:     if (w_mul_last) w_state_nxt = StIdle;
      StDivIter: if (r_cnt == CntW'(1)) w_state_nxt = StDivFix;
      StDivFix:  w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
    if (w_cancel) w_state_nxt = StIdle;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_mul_vld <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) r_mul_pipe[i] <= '0;
      r_dvs     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dz_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_cancel) begin
        r_mul_vld <= '0;
        r_cnt     <= '0;
        r_dz_pend <= 1'b0;
      end else begin
        // Multiplier pipeline
        r_mul_vld[0] <= w_acc_mul;
        if (w_acc_mul) r_mul_pipe[0] <= w_prod;
        for (int i = 1; i < MUL_LATENCY; i++) begin
          r_mul_vld[i]  <= r_mul_vld[i-1];
          r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
        if (w_mul_last) begin
          {r_hi, r_lo} <= r_mul_pipe[MUL_LATENCY-1];
          r_done       <= 1'b1;
        end

        if (w_accept && (i_op == OpMthi)) r_hi <= i_rs;
        if (w_accept && (i_op == OpMtlo)) r_lo <= i_rs;

        if (w_acc_div) begin
          r_dz      <= 1'b0;
          r_dvs     <= w_rt_abs;
          r_rem     <= '0;
          r_quo     <= w_rs_abs;
          r_q_neg   <= w_rs_neg ^ w_rt_neg;
          r_r_neg   <= w_rs_neg;
          r_cnt     <= CntW'(WIDTH);
          r_dz_pend <= 1'b0;
          if (w_rt_zero) begin
            // Raw dividend is parked in the quotient register for hi.
            r_quo     <= i_rs;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dz_pend <= 1'b1;
          end else if (w_early) begin
            r_quo <= '0;
            r_rem <= w_rs_abs;
          end
        end

        if (r_state == StDivIter) begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
        end

        if (r_state == StDivFix) begin
          r_done <= 1'b1;
          if (r_dz_pend) begin
            r_lo <= '1;
            r_hi <= r_quo;
            r_dz <= 1'b1;
          end else begin
            r_lo <= r_q_neg ? -r_quo : r_quo;
            r_hi <= r_r_neg ? -r_rem : r_rem;
          end
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_dz   = r_dz;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_LATENCY=2) with a scoreboard of
// expected hi/lo/dz/latency pushed at issue and popped at each done pulse.
module tb_mdu_iter;

  localparam int unsigned W  = 32;
  localparam int unsigned ML = 2;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic          clk, rst;
  logic [2:0]    i_op;
  logic          i_op_valid, i_cancel;
  logic [W-1:0]  i_rs, i_rt;
  logic          o_op_ready, o_stall, o_done, o_dz;
  logic [W-1:0]  o_hi, o_lo;

  mdu_iter #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_op      (i_op),
    .i_op_valid(i_op_valid),
    .o_op_ready(o_op_ready),
    .i_cancel  (i_cancel),
    .i_rs      (i_rs),
    .i_rt      (i_rt),
    .o_stall   (o_stall),
    .o_done    (o_done),
    .o_dz      (o_dz),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic m_dz  = 1'b0;  // model of the sticky flag

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] rs,
                                 input logic [W-1:0] rt);
    exp_t e;
    logic [2*W-1:0] a64, b64, p;
    logic [W-1:0] a, b, q, r;
    logic sg;
    e.hi = '0; e.lo = '0; e.dz = m_dz; e.lat = 0;
    if (op == OpMult || op == OpMultu) begin
      sg  = (op == OpMult);
      a64 = {{W{sg & rs[W-1]}}, rs};
      b64 = {{W{sg & rt[W-1]}}, rt};
      p   = a64 * b64;
      e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.lat = ML;
    end else begin
      sg = (op == OpDiv);
      if (rt == '0) begin
        e.lo = '1; e.hi = rs; e.dz = 1'b1; e.lat = 1;
      end else begin
        a = (sg && rs[W-1]) ? -rs : rs;
        b = (sg && rt[W-1]) ? -rt : rt;
        q = a / b;
        r = a % b;
        if (sg && (rs[W-1] ^ rt[W-1])) q = -q;
        if (sg && rs[W-1]) r = -r;
        e.lo = q; e.hi = r; e.dz = 1'b0; e.lat = W + 1;
`ifdef MDU_EARLY_OUT_EN
        if (a < b) e.lat = 1;
`endif
      end
    end
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    i_op = op; i_rs = rs; i_rt = rt; i_op_valid = 1'b1;
  endtask

  // Drive a MUL/DIV, optionally record its expectation, and step past the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                       input bit track);
    exp_t e;
    drive(op, rs, rt);
    if (track) begin
      e = model(op, rs, rt);
      m_dz = e.dz;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Wait for done with op_valid still held; compare against the scoreboard.
  task automatic wait_done(input string tag, input int budget);
    int   n = 0;
    bit   seen = 0;
    bit   busy_ok;
    exp_t e;
    busy_ok = !o_op_ready && o_stall;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (o_done) seen = 1;
      else if (o_op_ready || !o_stall) busy_ok = 0;
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    if (seen) begin
      chk({tag, " ready_in_done"}, 64'(o_op_ready), 64'd1);
      chk({tag, " stall_in_done"}, 64'(o_stall), 64'd0);
      chk({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, " latency"}, 64'(n), 64'(e.lat));
        chk({tag, " hi"}, 64'(o_hi), 64'(e.hi));
        chk({tag, " lo"}, 64'(o_lo), 64'(e.lo));
        chk({tag, " dz"}, 64'(o_dz), 64'(e.dz));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    rst = 1'b1; i_op = '0; i_op_valid = 1'b0; i_cancel = 1'b0; i_rs = '0; i_rt = '0;
    #2;
    chk("rst hi", 64'(o_hi), 64'd0);
    chk("rst lo", 64'(o_lo), 64'd0);
    chk("rst dz", 64'(o_dz), 64'd0);
    chk("rst done", 64'(o_done), 64'd0);
    chk("rst ready", 64'(o_op_ready), 64'd1);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // MULT with two-stage latency, then the done pulse must be one cycle wide.
    issue(OpMult, 32'hFFFF_FFFD, 32'h0000_0007, 1);
    wait_done("mult", 10);
    i_op_valid = 1'b0;
    @(posedge clk); #1;
    chk("mult done_pulse", 64'(o_done), 64'd0);

    issue(OpMultu, 32'hFFFF_FFFD, 32'h0000_0007, 1);
    wait_done("multu", 10);
    i_op_valid = 1'b0;

    // DIVU with a second (MTHI) request held while busy.
    issue(OpDivu, 32'd100, 32'd7, 1);
    drive(OpMthi, 32'hDEAD_BEEF, 32'd0);
    wait_done("divu", 50);
    @(posedge clk); #1;
    i_op_valid = 1'b0;
    chk("held mthi hi", 64'(o_hi), 64'hDEAD_BEEF);
    chk("held mthi lo", 64'(o_lo), 64'd14);

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done("div neg", 50);
    i_op_valid = 1'b0;
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done("div ovf", 50);
    i_op_valid = 1'b0;

    // Divide by zero, then the next divide clears the flag at accept.
    issue(OpDiv, 32'h1234_5678, 32'd0, 1);
    wait_done("div0", 10);
    i_op_valid = 1'b0;
    issue(OpDiv, 32'd9, 32'd3, 1);
    chk("dz clear at accept", 64'(o_dz), 64'd0);
    wait_done("div 9/3", 50);
    i_op_valid = 1'b0;

    // MTHI / MTLO
    drive(OpMthi, 32'hAAAA_5555, 32'd0);
    @(posedge clk); #1;
    chk("mthi hi", 64'(o_hi), 64'hAAAA_5555);
    chk("mthi done", 64'(o_done), 64'd0);
    drive(OpMtlo, 32'd1, 32'd0);
    @(posedge clk); #1;
    i_op_valid = 1'b0;
    chk("mtlo lo", 64'(o_lo), 64'd1);
    chk("mtlo hi", 64'(o_hi), 64'hAAAA_5555);
    chk("mtlo ready", 64'(o_op_ready), 64'd1);

    // Cancel together with op_valid in IDLE wins.
    drive(OpMthi, 32'h0BAD_F00D, 32'd0);
    i_cancel = 1'b1;
    @(posedge clk); #1;
    i_cancel = 1'b0; i_op_valid = 1'b0;
    chk("cancel idle hi", 64'(o_hi), 64'hAAAA_5555);

    // DIVU cancelled at iteration 10.
    issue(OpDivu, 32'd1000, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1;
    i_cancel = 1'b1; i_op_valid = 1'b0;
    @(posedge clk); #1;
    i_cancel = 1'b0;
    chk("cancel ready", 64'(o_op_ready), 64'd1);
    chk("cancel hi", 64'(o_hi), 64'hAAAA_5555);
    chk("cancel lo", 64'(o_lo), 64'd1);
    chk("cancel dz", 64'(o_dz), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_done) dcnt++;
    end
    chk("cancel no done", 64'(dcnt), 64'd0);

    // DIVU by zero sets the flag; a later divide is reset mid-flight.
    issue(OpDivu, 32'd5, 32'd0, 1);
    wait_done("divu0", 10);
    i_op_valid = 1'b0;
    issue(OpDivu, 32'd1000, 32'd3, 0);
    i_op_valid = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst hi", 64'(o_hi), 64'd0);
    chk("midrst lo", 64'(o_lo), 64'd0);
    chk("midrst dz", 64'(o_dz), 64'd0);
    chk("midrst ready", 64'(o_op_ready), 64'd1);
    m_dz = 1'b0;
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Small-dividend divides: early out when enabled, full length otherwise.
    issue(OpDivu, 32'd3, 32'd10, 1);
    wait_done("divu 3/10", 50);
    i_op_valid = 1'b0;
    issue(OpDiv, 32'hFFFF_FFFD, 32'd10, 1);
    wait_done("div -3/10", 50);
    i_op_valid = 1'b0;

    chk("sb empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO architectural registers of the single-cycle core.
- Successor to the fixed 32-bit MDU:
  - generic operand width;
  - configurable multiplier latency;
  - sequential radix-2 divider with a valid/ready handshake, done pulse, cancel and divide-by-zero flag.
- Sits beside the ALU. The control unit holds the PC (stall) while an issued MUL/DIV is outstanding.

Parameters:
- WIDTH, 32: operand width; hi/lo are WIDTH bits each; must be >= 4 and even.
- MUL_LATENCY, 1: edges from accept to hi/lo update for MULT/MULTU; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- op_valid  in  1  op/operands valid this cycle
- op_ready  out  1  unit can accept; high iff state IDLE
- cancel  in  1  synchronous abort of an in-flight MUL/DIV
- rs  in  WIDTH  dividend / multiplicand / MTHI-MTLO source
- rt  in  WIDTH  divisor / multiplier
- stall  out  1  combinational: (op_valid && op in 1..4 && !done) || (state != IDLE)
- done  out  1  one-cycle pulse in the cycle hi/lo hold a new MUL/DIV result
- dz  out  1  sticky divide-by-zero flag; cleared by the next accepted DIV/DIVU
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: rst high, at any time and asynchronously, forces:
  - state IDLE; hi=0, lo=0, done=0, dz=0; op_ready=1;
  - multiplier pipeline valid bits and divider counter cleared.
- Accept: accept edge = rising edge with op_valid && op_ready && op in 1..6. NOP, reserved op, and op_valid while not ready are ignored; the requester holds op/operands until done.
- MTHI/MTLO:
  - hi (or lo) <= rs at the accept edge; state stays IDLE.
  - No done pulse; not a stall source.
- MULT/MULTU:
  - Full 2*WIDTH product; operands sign-extended (MULT) or zero-extended (MULTU).
  - Product passes through MUL_LATENCY register stages; state MUL while stages are non-empty.
  - {hi,lo} <= product at edge accept+MUL_LATENCY; done=1 for the following cycle; return to IDLE on that edge.
- DIV/DIVU: states IDLE -> DIV_ITER -> DIV_FIX -> IDLE.
  - Accept edge:
    - latch |rs| and |rt| (DIV) or raw values (DIVU);
    - record quotient sign = rs[MSB]^rt[MSB] and remainder sign = rs[MSB] (DIV only);
    - remainder accumulator = 0, count = WIDTH.
  - DIV_ITER, one restoring iteration per edge:
    - shift {rem,quo} left 1;
    - if rem >= divisor, then subtract and set quo LSB;
    - count decrements; after WIDTH iterations go to DIV_FIX.
  - DIV_FIX edge:
    - apply signs (two's-complement negate);
    - lo <= quotient, hi <= remainder; done=1 next cycle.
  - Total: hi/lo updated at edge accept+WIDTH+1 (33 for WIDTH=32).
  - Rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case MIN/-1: lo=MIN, hi=0, no flag.
- Divide by zero (rt==0 at accept):
  - skip DIV_ITER; go straight to DIV_FIX;
  - lo <= all ones, hi <= rs, dz <= 1; done at edge accept+1.
- Cancel:
  - cancel high at an edge while state != IDLE: return to IDLE, discard the pipeline/divider contents, leave hi/lo/dz unchanged, no done.
  - cancel in IDLE has no effect.
  - cancel together with op_valid in IDLE: cancel wins, nothing accepted.
- done and accept coincide never: op_ready is low in the cycle before done (state still busy). op_ready rises in the done cycle, so back-to-back issue is possible one cycle after completion.
- stall drops in the done cycle, so the core advances exactly once per MUL/DIV instruction.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: at accept, if unsigned |rs| < |rt| and rt != 0, bypass DIV_ITER:
  - DIV_FIX writes quotient 0 and remainder rs (sign preserved);
  - done at edge accept+1.
- Undefined: all nonzero-divisor divides take WIDTH+1 edges; rs=0 is not special-cased.

Test Plan:
- MULT rs=FFFFFFFD, rt=00000007, MUL_LATENCY=2 -> hi=FFFFFFFF, lo=FFFFFFEB at edge accept+2; done one cycle; stall high for 2 cycles then low.
- DIVU rs=100, rt=7 -> lo=14, hi=2, done at edge accept+33; op_ready low throughout; a second op_valid held meanwhile is accepted only after done.
- DIV rs=FFFFFFF9 (-7), rt=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV rs=80000000, rt=FFFFFFFF -> lo=80000000, hi=0.
- DIV rs=12345678, rt=0 -> lo=FFFFFFFF, hi=12345678, dz=1, done at accept+1; next DIV 9/3 -> dz=0, lo=3, hi=0.
- MTHI rs=AAAA5555 then MTLO rs=1 -> hi=AAAA5555, lo=1 immediately, no done. Then DIVU with cancel at iteration 10 -> IDLE, hi/lo unchanged, no done.
- rst pulsed mid-divide (iteration 20) -> hi=lo=0, dz=0, op_ready=1 without waiting for a clock edge.
- With MDU_EARLY_OUT_EN: DIVU 3/10 -> lo=0, hi=3 at edge accept+1.
